// File: rtl/fifo_top.sv
// Single-clock show-ahead FIFO with registered full/empty flags.
// Define FIFO_TOP_COUNT_EN to add the registered occupancy output wcount.
module fifo_top #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 winc,
    input  logic                 rinc,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 wfull,
    output logic                 rempty
`ifdef FIFO_TOP_COUNT_EN
    ,
    output logic [ADDR_SIZE:0]   wcount
`endif
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [ADDR_SIZE:0]   wptr_q, wptr_d;
    logic [ADDR_SIZE:0]   rptr_q, rptr_d;
    logic                 wfull_q, wfull_d;
    logic                 rempty_q, rempty_d;
    logic                 wr_en, rd_en;

    // Acceptance depends only on registered flags, so winc/rinc never reach an output combinationally.
    always_comb begin
        wr_en    = winc & ~wfull_q & ~rst;
        rd_en    = rinc & ~rempty_q & ~rst;
        wptr_d   = wptr_q + (ADDR_SIZE+1)'(wr_en);
        rptr_d   = rptr_q + (ADDR_SIZE+1)'(rd_en);
        rempty_d = (wptr_d == rptr_d);
        wfull_d  = (wptr_d[ADDR_SIZE] != rptr_d[ADDR_SIZE]) &&
                   (wptr_d[ADDR_SIZE-1:0] == rptr_d[ADDR_SIZE-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[ADDR_SIZE-1:0]] <= wdata;
        end
    end

    assign rdata  = mem_q[rptr_q[ADDR_SIZE-1:0]];
    assign wfull  = wfull_q;
    assign rempty = rempty_q;

`ifdef FIFO_TOP_COUNT_EN
    logic [ADDR_SIZE:0] wcount_q, wcount_d;

    always_comb begin
        wcount_d = wptr_d - rptr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcount_q <= '0;
        end else begin
            wcount_q <= wcount_d;
        end
    end

    assign wcount = wcount_q;
`endif

endmodule

// File: tb/tb_fifo_top.sv
// Directed bench for fifo_top: vector table for basic behaviour plus
// hand-written overfill, drain, wrap, simultaneous and mid-run reset sequences.
module tb_fifo_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = '0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] rdata;
    logic       wfull;
    logic       rempty;
`ifdef FIFO_TOP_COUNT_EN
    logic [4:0] wcount;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fifo_top #(.DATA_SIZE(8), .ADDR_SIZE(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .wdata  (wdata),
        .winc   (winc),
        .rinc   (rinc),
        .rdata  (rdata),
        .wfull  (wfull),
        .rempty (rempty)
`ifdef FIFO_TOP_COUNT_EN
        ,
        .wcount (wcount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       winc;
        logic       rinc;
        logic [7:0] wdata;
        logic       e_empty;
        logic       e_full;
        int         e_cnt;
        logic       chk_data;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
        rst   = r;
        winc  = w;
        rinc  = rd;
        wdata = d;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic e_empty, input logic e_full, input int e_cnt);
        check({tag, ".rempty"}, int'(rempty), int'(e_empty));
        check({tag, ".wfull"}, int'(wfull), int'(e_full));
`ifdef FIFO_TOP_COUNT_EN
        check({tag, ".wcount"}, int'(wcount), e_cnt);
`else
        if (e_cnt < 0) $display("unexpected negative count");
`endif
    endtask

    initial begin
        //         rst  winc rinc wdata  empty full cnt chk  data
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 0, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1, 1'b1, 8'h11};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 2, 1'b1, 8'h11};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'h22};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1, 1'b1, 8'h33};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1, 1'b1, 8'h44};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 0, 1'b0, 8'h00};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].winc, vecs[i].rinc, vecs[i].wdata);
            check_state($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_full, vecs[i].e_cnt);
            if (vecs[i].chk_data) check($sformatf("vec%0d.rdata", i), int'(rdata), int'(vecs[i].e_data));
        end

        // Overfill: 20 writes of 1..20, only the first 16 land.
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(i));
            check_state($sformatf("fill%0d", i), 1'b0, (i >= 16), (i >= 16) ? 16 : i);
            check($sformatf("fill%0d.rdata", i), int'(rdata), 1);
        end

        // Drain: 20 reads, data 1..16 then extra reads do nothing.
        for (int i = 1; i <= 20; i++) begin
            if (i <= 16) check($sformatf("drain%0d.rdata", i), int'(rdata), i);
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check_state($sformatf("drain%0d", i), (i >= 16), 1'b0, (i >= 16) ? 0 : 16 - i);
        end

        // Wrap-around: pointers start at 16; write 10/read 10/write 16/read 16.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        check_state("wrap_w10", 1'b0, 1'b0, 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("wrap_r%0d", i), int'(rdata), i);
            step(1'b0, 1'b0, 1'b1, 8'h00);
        end
        check_state("wrap_r10", 1'b1, 1'b0, 0);
        for (int i = 10; i < 26; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(i));
            check_state($sformatf("wrap_w%0d", i), 1'b0, (i == 25), i - 9);
        end
        for (int i = 10; i < 26; i++) begin
            check($sformatf("wrap_r%0d", i), int'(rdata), i);
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check_state($sformatf("wrap_rs%0d", i), (i == 25), 1'b0, 25 - i);
        end

        // Simultaneous at occupancy 5.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        for (int k = 0; k < 8; k++) begin
            check($sformatf("simul%0d.rdata", k), int'(rdata), (k < 5) ? 8'h40 + k : 8'h50 + k - 5);
            step(1'b0, 1'b1, 1'b1, 8'(8'h50 + k));
            check_state($sformatf("simul%0d", k), 1'b0, 1'b0, 5);
        end

        // Fill to 16, then write+read while full: only the read is taken.
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        check_state("full16", 1'b0, 1'b1, 16);
        check("full.rdata", int'(rdata), 8'h53);
        step(1'b0, 1'b1, 1'b1, 8'h77);
        check_state("full_simul", 1'b0, 1'b0, 15);
        check("full_simul.rdata", int'(rdata), 8'h54);

        // Mid-run reset at occupancy 7.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
        check_state("occ7", 1'b0, 1'b0, 7);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check_state("midrst", 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 8'hA5);
        check_state("post_rst_wr", 1'b0, 1'b0, 1);
        check("post_rst_wr.rdata", int'(rdata), 8'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_top.md
# fifo_top

Single-clock synchronous FIFO with a parameterized data width and depth. It buffers words between a producer and a consumer that share one clock domain. A write-increment / read-increment handshake is used, and registered full/empty flags are exposed. Reads are show-ahead: the word at the head of the queue is always visible on the read-data output.

## Interface
Parameters:
- DATA_SIZE, default 8, word width in bits
- ADDR_SIZE, default 4, address width; depth DEPTH = 2^ADDR_SIZE (16 by default)

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk
- wdata  input  DATA_SIZE  write data
- winc  input  1  write request
- rinc  input  1  read request
- rdata  output  DATA_SIZE  head-of-queue data (show-ahead)
- wfull  output  1  FIFO holds DEPTH words
- rempty  output  1  FIFO holds 0 words
- wcount  output  ADDR_SIZE+1  occupancy; present only with FIFO_TOP_COUNT_EN

## Operation
- Storage: DEPTH x DATA_SIZE register array. The array is not reset.
- Pointers: wptr and rptr, each ADDR_SIZE+1 bits, binary.
  - The low ADDR_SIZE bits address the array.
  - The MSB is the wrap bit.
- Write accepted when winc=1 and wfull=0.
  - mem[wptr[ADDR_SIZE-1:0]] <= wdata.
  - wptr increments.
- Read accepted when rinc=1 and rempty=0.
  - rptr increments.
  - The data consumed is the rdata value presented during that cycle.
- Blocked requests have no effect on any state:
  - a write while wfull=1 is dropped;
  - a read while rempty=1 is ignored.
- Simultaneous accepted write and read: both pointers advance and occupancy is unchanged.
  - When full, only the read is accepted. The next cycle is not full.
  - When empty, only the write is accepted. The next cycle is not empty.
- Flags are computed from the next-state pointers and registered:
  - rempty = (wptr_next == rptr_next)
  - wfull = (wptr_next[ADDR_SIZE] != rptr_next[ADDR_SIZE]) and (wptr_next[ADDR_SIZE-1:0] == rptr_next[ADDR_SIZE-1:0])
- rdata = mem[rptr[ADDR_SIZE-1:0]], combinational from the array and rptr.
  - It is valid only while rempty=0.
  - While rempty=1, its value is don't-care.
- Pointer wrap is natural modulo-2^(ADDR_SIZE+1) rollover. Data order is preserved across the wrap.

## Timing
- Reset (rst=1 at a rising edge):
  - wptr=0, rptr=0, rempty=1, wfull=0, wcount=0.
  - Any winc/rinc in that cycle is ignored.
  - Reset mid-operation discards all contents immediately, with no drain.
- Write-to-read latency: 1 cycle.
  - After the first accepted write edge into an empty FIFO, rempty=0 and rdata equals that word in the same cycle.
- wfull asserts after the edge that accepts the DEPTH-th unread word.
  - It deasserts after the edge that accepts a read.
- rempty asserts after the edge that consumes the last word.
- One write and one read maximum per cycle.
- No combinational path from winc or rinc to any output.

## Configuration
- FIFO_TOP_COUNT_EN defined:
  - Adds output wcount = wptr - rptr (ADDR_SIZE+1 bits, range 0..DEPTH).
  - wcount is registered and updated on the same edge as the flags.
  - It resets to 0.
- FIFO_TOP_COUNT_EN not defined:
  - The wcount port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold rst=1 for 3 edges, then release.
  - Required: rempty=1, wfull=0, and wcount=0 if enabled.
- Overfill: winc=1 for 20 consecutive cycles with data 1..20.
  - Required: wfull=1 after the 16th accepted write.
  - Writes 17..20 are dropped.
  - wcount=16.
- Drain: after the overfill, rinc=1 for 20 cycles.
  - Required: rdata sequence 1..16 in order.
  - rempty=1 after the 16th read.
  - The extra reads change nothing.
- Wrap-around: write 10, read 10, write 16, read 16 (values 0x00..0x19).
  - Required: all words return in order across the pointer wrap.
  - The flags are correct at the 0 and 16 occupancy boundaries.
- Simultaneous: at occupancy 5, winc=rinc=1 for 8 cycles.
  - Required: occupancy stays 5 and FIFO order is preserved.
  - When full, only the read is accepted. When empty, only the write is accepted.
- Reset mid-operation: at occupancy 7, assert rst for 1 edge.
  - Required: rempty=1, wfull=0 and wcount=0 on the next cycle.
  - A subsequent write of 0xA5 appears on rdata one cycle later.
